uart_tx: RTL and testbench

Serial transmitter for the UART system. It consumes the oversampling tick produced by the baud-rate counter and serialises one parallel word per request onto the `tx` line. The frame is: start bit, DBIT data bits sent LSB first, an optional parity bit, and a stop period. It sits between the host-side TX FIFO/controller and the pad, and is the transmit-side counterpart of the tick-generating counter.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first,
// optional parity bit, then a stop period, all paced by s_tick.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OS      = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    // Parity codes other than 1/2 mean no parity bit at all.
    localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: each bit lasts a fixed number of s_ticks.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = din;
                    p_d     = PAR_ODD;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? PAR : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the next state so it moves on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PAR:     tx_d = p_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameter variants, frames
// decoded per s_tick by a monitor and checked against queued words.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       stall;
    logic [8:0] din;
    logic       start [4];
    logic       tx_w  [4];
    logic       busy_w[4];
    logic       done_w[4];

    int tests;
    int fails;

    typedef struct {
        int         id;
        logic [8:0] data;
        int         nb;
        int         has_par;
        logic       pb;
        int         sb;
        int         ticks;
        int         clks;
    } exp_t;

    exp_t q[$];

    bit smp [4][512];
    int slen[4];
    int bclk[4];
    bit pdone[4];

    uart_tx #(.DBIT(8), .SB_TICK(16), .OS(16), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start[0]), .din(din[7:0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
    );
    uart_tx #(.DBIT(8), .SB_TICK(16), .OS(16), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start[1]), .din(din[7:0]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
    );
    uart_tx #(.DBIT(8), .SB_TICK(16), .OS(16), .PARITY(2)) dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start[2]), .din(din[7:0]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2])
    );
    uart_tx #(.DBIT(7), .SB_TICK(32), .OS(16), .PARITY(0)) dut3 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start[3]), .din(din[6:0]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // s_tick every 4 clks, frozen while stall is set.
    initial begin
        int tc;
        tc = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                s_tick = 1'b0;
            end else begin
                tc = (tc + 1) % 4;
                s_tick = (tc == 0);
            end
        end
    end

    task automatic check_frame(int d);
        exp_t e;
        bit   ex[512];
        int   k;
        int   bad;
        int   first;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done dut%0d: got done, required none", d);
            return;
        end
        e = q.pop_front();
        tests++;
        if (e.id != d) begin
            fails++;
            $display("FAIL done_source: got dut%0d, required dut%0d", d, e.id);
        end
        k = 0;
        for (int i = 0; i < 16; i++) begin ex[k] = 1'b0; k++; end
        for (int j = 0; j < e.nb; j++)
            for (int i = 0; i < 16; i++) begin ex[k] = e.data[j]; k++; end
        if (e.has_par != 0)
            for (int i = 0; i < 16; i++) begin ex[k] = e.pb; k++; end
        for (int i = 0; i < e.sb; i++) begin ex[k] = 1'b1; k++; end
        tests++;
        if (slen[d] != e.ticks || k != e.ticks) begin
            fails++;
            $display("FAIL frame_len dut%0d data=%h: got %0d ticks, required %0d",
                     d, e.data, slen[d], e.ticks);
        end
        bad = 0;
        first = -1;
        for (int i = 0; i < k && i < slen[d]; i++) begin
            if (smp[d][i] != ex[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL frame_bits dut%0d data=%h: tick %0d got %b, required %b (%0d bad)",
                     d, e.data, first, smp[d][first], ex[first], bad);
        end
        if (e.clks >= 0) begin
            tests++;
            if (bclk[d] != e.clks) begin
                fails++;
                $display("FAIL done_latency dut%0d: got %0d clks, required %0d",
                         d, bclk[d], e.clks);
            end
        end
    endtask

    // Monitor: samples tx once per s_tick while busy; checks on done.
    initial begin
        for (int d = 0; d < 4; d++) begin
            slen[d] = 0; bclk[d] = 0; pdone[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (reset) begin
                    slen[d] = 0;
                    bclk[d] = 0;
                    pdone[d] = 1'b0;
                end else begin
                    if (pdone[d]) begin
                        tests++;
                        if (done_w[d]) begin
                            fails++;
                            $display("FAIL done_width dut%0d: got 2+ clks, required 1", d);
                        end
                    end
                    if (done_w[d]) begin
                        check_frame(d);
                        slen[d] = 0;
                        bclk[d] = 0;
                    end
                    if (busy_w[d]) begin
                        bclk[d]++;
                        if (s_tick && slen[d] < 512) begin
                            smp[d][slen[d]] = tx_w[d];
                            slen[d]++;
                        end
                    end
                    pdone[d] = done_w[d];
                end
            end
        end
    end

    task automatic push(int d, logic [8:0] v, int nb, int hp,
                        logic pb, int sb, int ticks, int clks);
        exp_t e;
        e.id = d; e.data = v; e.nb = nb; e.has_par = hp;
        e.pb = pb; e.sb = sb; e.ticks = ticks; e.clks = clks;
        q.push_back(e);
    endtask

    task automatic send(int d, logic [8:0] v, bit align);
        @(posedge clk);
        #2;
        if (align) begin
            while (!s_tick) begin
                @(posedge clk);
                #2;
            end
        end
        din = v;
        start[d] = 1'b1;
        @(posedge clk);
        #2;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(int d);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk);
            #2;
            if (done_w[d]) break;
        end
        tests++;
        if (k == 3000) begin
            fails++;
            $display("FAIL timeout dut%0d: got no done, required done", d);
        end
    endtask

    task automatic chk(string name, logic got, logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    initial begin
        logic txs;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        stall = 1'b0;
        din = '0;
        for (int d = 0; d < 4; d++) start[d] = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_tx%0d", d), tx_w[d], 1'b1);
            chk($sformatf("reset_busy%0d", d), busy_w[d], 1'b0);
            chk($sformatf("reset_done%0d", d), done_w[d], 1'b0);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame, acceptance on a tick edge: 160 ticks, 640 clks.
        push(0, 9'h0A5, 8, 0, 1'b0, 16, 160, 640);
        send(0, 9'h0A5, 1'b1);
        chk("basic_tx_low", tx_w[0], 1'b0);
        chk("basic_busy", busy_w[0], 1'b1);
        wait_done(0);

        // Parity variants.
        push(1, 9'h007, 8, 1, 1'b1, 16, 176, -1);
        send(1, 9'h007, 1'b0);
        wait_done(1);
        push(2, 9'h007, 8, 1, 1'b0, 16, 176, -1);
        send(2, 9'h007, 1'b0);
        wait_done(2);
        push(1, 9'h000, 8, 1, 1'b0, 16, 176, -1);
        send(1, 9'h000, 1'b1);
        wait_done(1);
        push(2, 9'h000, 8, 1, 1'b1, 16, 176, -1);
        send(2, 9'h000, 1'b0);
        wait_done(2);

        // Start request mid-DATA must be ignored.
        push(0, 9'h012, 8, 0, 1'b0, 16, 160, -1);
        send(0, 9'h012, 1'b0);
        repeat (200) @(posedge clk);
        #2;
        din = 9'h0FF;
        start[0] = 1'b1;
        @(posedge clk);
        #2;
        start[0] = 1'b0;
        wait_done(0);
        @(posedge clk);
        #2;
        chk("ignored_idle", busy_w[0], 1'b0);

        // Back-to-back with tx_start held through the done cycle.
        push(0, 9'h03C, 8, 0, 1'b0, 16, 160, -1);
        push(0, 9'h0C3, 8, 0, 1'b0, 16, 160, -1);
        @(posedge clk);
        #2;
        din = 9'h03C;
        start[0] = 1'b1;
        @(posedge clk);
        #2;
        din = 9'h0C3;
        wait_done(0);
        @(posedge clk);
        #2;
        chk("b2b_tx_low", tx_w[0], 1'b0);
        chk("b2b_busy", busy_w[0], 1'b1);
        start[0] = 1'b0;
        wait_done(0);

        // Async reset during the 4th data bit.
        send(0, 9'h0FF, 1'b1);
        repeat (280) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_tx", tx_w[0], 1'b1);
        chk("arst_busy", busy_w[0], 1'b0);
        chk("arst_done", done_w[0], 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        push(0, 9'h05A, 8, 0, 1'b0, 16, 160, 640);
        send(0, 9'h05A, 1'b1);
        wait_done(0);

        // DBIT=7, two stop bits.
        push(3, 9'h055, 7, 0, 1'b0, 32, 160, -1);
        send(3, 9'h055, 1'b0);
        wait_done(3);

        // Tick stall mid-bit holds the line.
        push(3, 9'h02B, 7, 0, 1'b0, 32, 160, -1);
        send(3, 9'h02B, 1'b0);
        repeat (150) @(posedge clk);
        #2;
        stall = 1'b1;
        @(posedge clk);
        #2;
        txs = tx_w[3];
        repeat (100) @(posedge clk);
        #2;
        chk("stall_tx", tx_w[3], txs);
        chk("stall_busy", busy_w[3], 1'b1);
        stall = 1'b0;
        wait_done(3);

        repeat (50) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_empty: got %0d pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
